// File: rtl/rst_sync_seq.sv
// Multi-channel reset synchroniser and sequencer. Resets assert asynchronously, then release one channel at a time in ascending order.
// Optional software reset request is compiled in when RST_SEQ_SWREQ_EN is defined.
module rst_sync_seq #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 4,
  parameter int GAP_CYC     = 3
) (
  input  logic              clk,
  input  logic              rstn_async,
`ifdef RST_SEQ_SWREQ_EN
  input  logic              sw_rst_req,
`endif
  output logic [NUM_CH-1:0] rstn,
  output logic              rst_done,
  output logic              busy
);

  localparam int CNT_MAX = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rst_sync_seq: NUM_CH must be in 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("rst_sync_seq: SYNC_STAGES must be in 2..4");
  end
  if (STRETCH_CYC < 1) begin : g_bad_stretch
    $error("rst_sync_seq: STRETCH_CYC must be at least 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $error("rst_sync_seq: GAP_CYC must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_ok;
  logic                   sync_arm;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) sync_reg[gi] <= 1'b0;
        else             sync_reg[gi] <= 1'b1;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) sync_reg[gi] <= 1'b0;
        else             sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign sync_ok  = sync_reg[SYNC_STAGES-1];
  // The stage before sync_ok lets the FSM enter STRETCH on the very edge sync_ok rises,
  // so the stretch is counted from that edge.
  assign sync_arm = sync_reg[SYNC_STAGES-2];

  typedef enum logic [1:0] {
    ST_RESET,
    ST_STRETCH,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [NUM_CH-1:0] rstn_reg, rstn_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
`ifdef RST_SEQ_SWREQ_EN
  logic              hold_reg, hold_next;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rstn_next  = rstn_reg;
    done_next  = done_reg;
`ifdef RST_SEQ_SWREQ_EN
    hold_next  = hold_reg;
`endif

    case (state_reg)
      ST_RESET: begin
        rstn_next = '0;
        done_next = 1'b0;
        if (sync_arm || sync_ok) begin
          state_next = ST_STRETCH;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      ST_STRETCH: begin
        if (cnt_reg == CNT_W'(STRETCH_CYC - 1)) begin
          rstn_next[0] = 1'b1;
          cnt_next     = '0;
          if (NUM_CH == 1) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RELEASE;
            idx_next   = IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_reg == CNT_W'(GAP_CYC - 1)) begin
          rstn_next[idx_reg] = 1'b1;
          cnt_next           = '0;
          if (idx_reg == IDX_W'(NUM_CH - 1)) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rstn_next = '1;
        done_next = 1'b1;
      end
      default: begin
        state_next = ST_RESET;
        rstn_next  = '0;
        done_next  = 1'b0;
      end
    endcase

`ifdef RST_SEQ_SWREQ_EN
    // The first edge with the request low behaves like a fresh STRETCH entry.
    if (state_reg != ST_RESET) begin
      if (sw_rst_req) begin
        state_next = ST_STRETCH;
        cnt_next   = '0;
        idx_next   = '0;
        rstn_next  = '0;
        done_next  = 1'b0;
        hold_next  = 1'b1;
      end else if (hold_reg) begin
        state_next = ST_STRETCH;
        cnt_next   = '0;
        idx_next   = '0;
        rstn_next  = '0;
        done_next  = 1'b0;
        hold_next  = 1'b0;
      end
    end
`endif

    busy_next = (state_next == ST_STRETCH) || (state_next == ST_RELEASE);
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_reg <= ST_RESET;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rstn_reg  <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef RST_SEQ_SWREQ_EN
      hold_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rstn_reg  <= rstn_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
`ifdef RST_SEQ_SWREQ_EN
      hold_reg  <= hold_next;
`endif
    end
  end

  assign rstn     = rstn_reg;
  assign rst_done = done_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: several parameter sets share one clock and reset; each has a scoreboard of expected release edges.
module tb_rst_sync_seq;

  localparam int NCFG = 6;
  localparam int NCH [NCFG] = '{3, 1, 4, 2, 4, 3};
  localparam int NSY [NCFG] = '{2, 3, 4, 3, 2, 4};
  localparam int NST [NCFG] = '{4, 1, 4, 2, 3, 1};
  localparam int NGP [NCFG] = '{3, 3, 5, 1, 2, 4};

  logic clk;
  logic rstn_async;
`ifdef RST_SEQ_SWREQ_EN
  logic sw_rst_req;
`endif

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s observed=%0h required=%0h at %0t", tag, obs, req, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int N  = NCH[gi];
    localparam int S  = NSY[gi];
    localparam int ST = NST[gi];
    localparam int G  = NGP[gi];

    logic [N-1:0] r;
    logic         bz;
    logic         dn;

    rst_sync_seq #(
      .NUM_CH      (N),
      .SYNC_STAGES (S),
      .STRETCH_CYC (ST),
      .GAP_CYC     (G)
    ) u_dut (
      .clk        (clk),
      .rstn_async (rstn_async),
`ifdef RST_SEQ_SWREQ_EN
      .sw_rst_req (sw_rst_req),
`endif
      .rstn       (r),
      .rst_done   (dn),
      .busy       (bz)
    );

    // Each entry: channel in the upper half, expected release edge in the lower half.
    int q[$];

    initial begin : model
      int n, base, entry, last, e;
      bit armed, live, hold, started, clk_q, arst_q;
      logic [N-1:0] r_prev, exp_r;
      n = 0; base = 0; entry = 0; last = 0; e = 0;
      armed = 0; live = 0; hold = 0; started = 0; clk_q = 0; arst_q = 1;
      r_prev = '0; exp_r = '0;
      forever begin
        @(posedge clk or negedge clk or negedge rstn_async);
        if (arst_q && !rstn_async) begin
          arst_q = 0; armed = 1; live = 0; hold = 0; started = 1;
          q.delete();
          r_prev = '0;
          #1;
          check_eq($sformatf("c%0d_arst_rstn", gi), 32'(r), 32'd0);
          check_eq($sformatf("c%0d_arst_done", gi), 32'(dn), 32'd0);
          check_eq($sformatf("c%0d_arst_busy", gi), 32'(bz), 32'd0);
        end else if (clk && !clk_q) begin
          clk_q = 1;
          n++;
          if (armed) begin
            if (rstn_async) begin
              armed = 0; live = 1;
              base  = n + S - 1;
              entry = base;
              for (int k = 0; k < N; k++) q.push_back(k * 65536 + base + ST + k * G);
            end
          end else if (live) begin
`ifdef RST_SEQ_SWREQ_EN
            if (sw_rst_req && n > entry) begin
              hold = 1;
              q.delete();
            end else if (hold) begin
              hold = 0;
              base = n;
              for (int k = 0; k < N; k++) q.push_back(k * 65536 + base + ST + k * G);
            end
`endif
          end
        end else if (!clk && clk_q) begin
          clk_q = 0;
          if (started) begin
            last = base + ST + (N - 1) * G;
            for (int k = 0; k < N; k++) exp_r[k] = live && !hold && (n >= base + ST + k * G);
            check_eq($sformatf("c%0d_rstn_e%0d", gi, n), 32'(r), 32'(exp_r));
            check_eq($sformatf("c%0d_busy_e%0d", gi, n), 32'(bz),
                     32'(live && (hold || (n >= base && n < last))));
            check_eq($sformatf("c%0d_done_e%0d", gi, n), 32'(dn),
                     32'(live && !hold && n >= last));
            for (int k = 0; k < N; k++) begin
              if (r[k] === 1'b1 && r_prev[k] !== 1'b1) begin
                $display("c%0d release ch=%0d edge=%0d", gi, k, n);
                if (q.size() == 0) begin
                  check_eq($sformatf("c%0d_spurious_ch%0d", gi, k), 32'(r[k]), 32'd0);
                end else begin
                  e = q.pop_front();
                  check_eq($sformatf("c%0d_rel_order", gi), 32'(k), 32'(e / 65536));
                  check_eq($sformatf("c%0d_rel_edge_ch%0d", gi, k), 32'(n), 32'(e % 65536));
                end
              end
            end
            r_prev = r;
          end
        end
        arst_q = rstn_async;
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn_async = 1'b1;
`ifdef RST_SEQ_SWREQ_EN
    sw_rst_req = 1'b0;
`endif
    #1 rstn_async = 1'b0;

    // Power-up sequence.
    repeat (3) @(negedge clk);
    #2 rstn_async = 1'b1;
    repeat (40) @(posedge clk);

    // Reset right after channel 0 releases.
    @(negedge clk);
    #2 rstn_async = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn_async = 1'b1;
    for (int i = 0; i < 60 && g[0].r[0] !== 1'b1; i++) @(negedge clk);
    check_eq("t2_rstn0_seen", 32'(g[0].r[0]), 32'd1);
    #2 rstn_async = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn_async = 1'b1;
    repeat (40) @(posedge clk);

    // Sub-cycle glitch while in DONE.
    @(posedge clk);
    #1 rstn_async = 1'b0;
    #3 rstn_async = 1'b1;
    repeat (40) @(posedge clk);

    // Restarts at random points of the sequence.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      repeat ($urandom_range(2, 20)) @(negedge clk);
      #2 rstn_async = 1'b0;
      @(negedge clk);
      #2 rstn_async = 1'b1;
    end
    repeat (40) @(posedge clk);

`ifdef RST_SEQ_SWREQ_EN
    // Software request for two cycles while in DONE.
    @(negedge clk);
    #2 sw_rst_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 sw_rst_req = 1'b0;
    repeat (40) @(posedge clk);

    // Software request mid-sequence, held three cycles.
    @(negedge clk);
    #2 rstn_async = 1'b0;
    @(negedge clk);
    #2 rstn_async = 1'b1;
    repeat (12) @(negedge clk);
    #2 sw_rst_req = 1'b1;
    repeat (3) @(negedge clk);
    #2 sw_rst_req = 1'b0;
    repeat (40) @(posedge clk);
`endif

    @(negedge clk);
    check_eq("final_rstn_c0", 32'(g[0].r), 32'h7);
    check_eq("final_done_c0", 32'(g[0].dn), 32'd1);
    check_eq("final_rstn_c2", 32'(g[2].r), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
